uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one UART transmitter.
// Each grant latches one byte, strobes uart_start, then waits for the done edge or a timeout.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int DATA_W       = 8,
  parameter int START_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int TIMEOUT      = 20000,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] data,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        err,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   uart_start,
  output logic [DATA_W-1:0]      uart_tx_input,
  input  logic                   uart_tx_done,
  output logic [1:0]             state_dbg
);

  // Handshake: a requester raises req[i] with its byte on data and holds both
  // until it sees a one-cycle ack[i] (sent) or err[i] (timed out). The byte is
  // captured on the grant cycle only, so req may drop early without aborting.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int SW = $clog2(START_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [SW-1:0]   START_LAST = SW'(START_CYCLES - 1);
  localparam logic [GW-1:0]   GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam bit              TO_EN      = (TIMEOUT != 0);
  localparam logic [15:0]     TO_LAST    = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE        = 1;

  state_t            state;
  logic [IDW-1:0]    ptr;
  logic [SW-1:0]     start_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [15:0]       to_cnt;
  logic              done_q;
  logic              done_edge;
  logic              pick_valid;
  logic [IDW-1:0]    pick_id;
  logic [DATA_W-1:0] data_arr [NREQ];

  assign done_edge = uart_tx_done & ~done_q;
  assign state_dbg = state;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = data[i*DATA_W +: DATA_W];
    end
  end

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    logic [IDW-1:0] idx;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ptr           <= IDW'(NREQ - 1);
      grant_id      <= '0;
      uart_tx_input <= '0;
      uart_start    <= 1'b0;
      busy          <= 1'b0;
      ack           <= '0;
      err           <= '0;
      start_cnt     <= '0;
      gap_cnt       <= '0;
      to_cnt        <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= uart_tx_done;
      ack    <= '0;
      err    <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state         <= S_START;
            grant_id      <= pick_id;
            uart_tx_input <= data_arr[pick_id];
            uart_start    <= 1'b1;
            busy          <= 1'b1;
            start_cnt     <= '0;
          end
        end
        S_START: begin
          if (start_cnt == START_LAST) begin
            uart_start <= 1'b0;
            state      <= S_WAIT;
            to_cnt     <= '0;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          // A done edge in the same cycle as the timeout counts as success.
          if (done_edge) begin
            ack     <= ONE << grant_id;
            ptr     <= grant_id;
            state   <= S_GAP;
            gap_cnt <= '0;
          end else if (TO_EN && to_cnt == TO_LAST) begin
            err     <= ONE << grant_id;
            ptr     <= grant_id;
            state   <= S_GAP;
            gap_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
